// File: rtl/mux_4_rr_arbiter.sv
// Round-robin arbiter for a shared 4-to-1 data mux feeding one valid/ready
// channel. A requester holds the grant for up to MAX_BURST accepted beats or
// until it drops its request. Priority then rotates to the next index, and
// the next owner is chosen on the same edge so that no idle cycle is inserted.
//
// state   | meaning
// S_IDLE  | no owner, o_Grant=0000, waiting for any request
// S_GRANT | requester o_Sel owns the channel, o_Grant=one-hot(o_Sel)
module mux_4_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic [3:0]            i_Req,
    input  logic [DATA_WIDTH-1:0] i_Data0,
    input  logic [DATA_WIDTH-1:0] i_Data1,
    input  logic [DATA_WIDTH-1:0] i_Data2,
    input  logic [DATA_WIDTH-1:0] i_Data3,
    output logic [3:0]            o_Grant,
    output logic [1:0]            o_Sel,
    output logic                  o_Valid,
    output logic [DATA_WIDTH-1:0] o_Data,
    input  logic                  i_Ready
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sel, w_sel_nxt;
    logic [1:0]      r_ptr, w_ptr_nxt;
    logic [3:0]      r_grant, w_grant_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic [1:0]      w_arb_ptr;
    logic [1:0]      w_scan_idx;
    logic [1:0]      w_win_idx;
    logic            w_win_vld;
    logic            w_valid;
    logic            w_beat;
    logic            w_release;

    // On release the pointer moves past the current owner before re-arbitrating,
    // so the scan in GRANT starts at r_sel+1 rather than the stored pointer.
    assign w_arb_ptr = (r_state == S_GRANT) ? (r_sel + 2'd1) : r_ptr;
    assign w_valid   = (r_state == S_GRANT) & i_Req[r_sel];
    assign w_beat    = w_valid & i_Ready;
    assign w_release = (r_state == S_GRANT) &
                       ((w_beat & (r_cnt == LAST_BEAT)) | ~i_Req[r_sel]);

    // Priority scan: walk from the farthest offset down so the closest request wins.
    always_comb begin
        w_win_vld  = 1'b0;
        w_win_idx  = w_arb_ptr;
        w_scan_idx = w_arb_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_scan_idx = w_arb_ptr + 2'(k);
            if (i_Req[w_scan_idx]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_scan_idx;
            end
        end
    end

    // State and grant registers, cleared asynchronously.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd0;
            r_grant <= 4'b0000;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: grant on any request, count beats, release and re-arbitrate.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_win_idx;
                    w_grant_nxt = 4'b0001 << w_win_idx;
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt = r_sel + 2'd1;
                    w_cnt_nxt = '0;
                    if (w_win_vld) begin
                        w_sel_nxt   = w_win_idx;
                        w_grant_nxt = 4'b0001 << w_win_idx;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_grant_nxt = 4'b0000;
                    end
                end else if (w_beat) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
            end
        endcase
    end

    // Output logic: data is forced to zero whenever the channel is not valid.
    always_comb begin
        o_Valid = w_valid;
        o_Data  = '0;
        if (w_valid) begin
            case (r_sel)
                2'd0:    o_Data = i_Data0;
                2'd1:    o_Data = i_Data1;
                2'd2:    o_Data = i_Data2;
                default: o_Data = i_Data3;
            endcase
        end
    end

    assign o_Grant = r_grant;
    assign o_Sel   = r_sel;

endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// Directed bench for mux_4_rr_arbiter with MAX_BURST=4, DATA_WIDTH=8.
module tb_mux_4_rr_arbiter;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic [3:0] i_Req;
    logic [7:0] i_Data0, i_Data1, i_Data2, i_Data3;
    logic       i_Ready;
    logic [3:0] o_Grant;
    logic [1:0] o_Sel;
    logic       o_Valid;
    logic [7:0] o_Data;

    int n_tests = 0;
    int n_fail  = 0;

    mux_4_rr_arbiter #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Req   (i_Req),
        .i_Data0 (i_Data0),
        .i_Data1 (i_Data1),
        .i_Data2 (i_Data2),
        .i_Data3 (i_Data3),
        .o_Grant (o_Grant),
        .o_Sel   (o_Sel),
        .o_Valid (o_Valid),
        .o_Data  (o_Data),
        .i_Ready (i_Ready)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic do_reset();
        i_Req   = 4'b0000;
        i_Ready = 1'b0;
        i_Rst_L = 1'b0;
        #2;
        i_Rst_L = 1'b1;
        #1;
    endtask

    function automatic logic [7:0] data_of(input logic [1:0] s);
        case (s)
            2'd0:    return i_Data0;
            2'd1:    return i_Data1;
            2'd2:    return i_Data2;
            default: return i_Data3;
        endcase
    endfunction

    logic [1:0] exp_sel;
    logic [1:0] order6 [0:8];
    logic       rdy_pat [0:6];

    initial begin
        i_Data0 = 8'hA0; i_Data1 = 8'hB1; i_Data2 = 8'h00; i_Data3 = 8'hD3;
        i_Req = 4'b0000; i_Ready = 1'b0; i_Rst_L = 1'b0;
        #3;
        check("rst_grant", o_Grant, 4'b0000);
        check("rst_sel",   o_Sel,   2'd0);
        check("rst_valid", o_Valid, 1'b0);
        check("rst_data",  o_Data,  8'h00);

        // Test 1: async reset mid-burst
        i_Rst_L = 1'b1; i_Req = 4'b1111; i_Ready = 1'b1;
        tick();
        check("t1_grant0", o_Grant, 4'b0001);
        check("t1_data0",  o_Data,  8'hA0);
        tick();
        #2;
        i_Rst_L = 1'b0;
        #1;
        check("t1_rst_grant", o_Grant, 4'b0000);
        check("t1_rst_valid", o_Valid, 1'b0);
        check("t1_rst_data",  o_Data,  8'h00);
        i_Rst_L = 1'b1;
        tick();
        check("t1_regrant", o_Grant, 4'b0001);
        check("t1_resel",   o_Sel,   2'd0);

        // Test 2: lone requester 2 keeps the channel across burst boundaries
        do_reset();
        i_Req = 4'b0100; i_Ready = 1'b1; i_Data2 = 8'h00;
        tick();
        for (int i = 0; i < 9; i++) begin
            check("t2_grant", o_Grant, 4'b0100);
            check("t2_sel",   o_Sel,   2'd2);
            check("t2_valid", o_Valid, 1'b1);
            check("t2_data",  o_Data,  8'(i));
            tick();
            i_Data2 = 8'(i + 1);
            #1;
        end

        // Test 3: full contention, 4 beats each, order 0,1,2,3,0
        do_reset();
        i_Req = 4'b1111; i_Ready = 1'b1;
        i_Data2 = 8'hC2;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_sel = 2'((i / 4) % 4);
            check("t3_sel",   o_Sel,   exp_sel);
            check("t3_grant", o_Grant, 4'b0001 << exp_sel);
            check("t3_valid", o_Valid, 1'b1);
            check("t3_data",  o_Data,  data_of(exp_sel));
        end

        // Test 4: backpressure on requester 1, release after 4th accepted beat
        do_reset();
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        rdy_pat[4] = 1'b1; rdy_pat[5] = 1'b0; rdy_pat[6] = 1'b1;
        i_Req = 4'b0110; i_Ready = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            i_Ready = rdy_pat[k];
            #1;
            check("t4_grant", o_Grant, 4'b0010);
            check("t4_valid", o_Valid, 1'b1);
            check("t4_data",  o_Data,  8'hB1);
            tick();
        end
        check("t4_next_grant", o_Grant, 4'b0100);
        check("t4_next_sel",   o_Sel,   2'd2);

        // Test 5: requester 0 drops after 2 beats
        do_reset();
        i_Req = 4'b0011; i_Ready = 1'b1;
        tick();
        check("t5_grant0", o_Grant, 4'b0001);
        tick();
        check("t5_grant1", o_Grant, 4'b0001);
        tick();
        i_Req = 4'b0010;
        #1;
        check("t5_drop_valid", o_Valid, 1'b0);
        check("t5_drop_data",  o_Data,  8'h00);
        tick();
        check("t5_new_grant", o_Grant, 4'b0010);
        check("t5_new_sel",   o_Sel,   2'd1);
        check("t5_new_data",  o_Data,  8'hB1);

        // Test 6: pointer wraps from 3 to 0 while a new request joins
        do_reset();
        i_Req = 4'b1000; i_Ready = 1'b1;
        tick();
        check("t6_own3", o_Sel, 2'd3);
        i_Req = 4'b1001;
        tick();
        tick();
        tick();
        check("t6_own3_last", o_Sel, 2'd3);
        i_Req = 4'b1011;
        order6[0] = 2'd0; order6[1] = 2'd0; order6[2] = 2'd0; order6[3] = 2'd0;
        order6[4] = 2'd1; order6[5] = 2'd1; order6[6] = 2'd1; order6[7] = 2'd1;
        order6[8] = 2'd3;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t6_sel",   o_Sel,   order6[i]);
            check("t6_grant", o_Grant, 4'b0001 << order6[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
